vx_alu_dot8: RTL and testbench
==============================

Name: vx_alu_dot8

Overview:
- Packed 8-bit dot-product processing element inside each ALU block.
- Sits directly downstream of the per-block PE switch, on the DOT8 slot. Consumes execute transactions whose op_type is DOT8 and returns per-lane 32-bit results on the result side of the switch.
- Each lane treats rs1/rs2 as four packed bytes and returns sum(a_i*b_i).
- Fixed-latency pipeline with bubble-collapsing backpressure.

Parameters:
- NUM_LANES, 4, number of SIMD lanes processed per transaction.
- XLEN, 32, register width. Must be 32; rs data holds 4 bytes.
- LATENCY, 2, pipeline depth in cycles from accept to result_valid. Must be ≥ 2: multiply stage plus add-tree stage; extra stages are pure registers.
- TAG_WIDTH, 64, width of opaque sideband: uuid, wid, PC, rd, wb, pid, sop, eop. Carried unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- execute_valid  in  1  input transaction valid
- execute_ready  out  1  block can accept this cycle
- execute_tag  in  TAG_WIDTH  opaque sideband
- execute_tmask  in  NUM_LANES  thread mask
- execute_is_signed  in  1  1 = signed int8 operands, 0 = unsigned uint8
- execute_rs1  in  NUM_LANES*XLEN  packed A bytes per lane
- execute_rs2  in  NUM_LANES*XLEN  packed B bytes per lane
- result_valid  out  1  result valid
- result_ready  in  1  downstream accepts
- result_tag  out  TAG_WIDTH  sideband of the transaction
- result_tmask  out  NUM_LANES  thread mask of the transaction
- result_data  out  NUM_LANES*XLEN  per-lane dot product

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: all stage valid bits clear, so result_valid=0. execute_ready=1 in the first cycle after reset deasserts. Data/tag registers are not reset; their contents are don't-care while invalid.
- Handshake:
  - Transfer occurs on valid&&ready at either port.
  - execute_ready must not depend combinationally on execute_valid.
  - result_* hold stable while result_valid && !result_ready.
- Pipeline: stages S0..S(LATENCY-1), each with a valid bit v[s]. S(LATENCY-1) drives the result_* outputs.
  - adv[L-1] = !v[L-1] || result_ready.
  - adv[s] = !v[s] || adv[s+1]; this collapses bubbles.
  - execute_ready = adv[0].
  - When adv[s] is true, the stage loads from the previous stage (or from the input for S0) and its valid bit becomes the incoming valid.
- Arithmetic, per lane j, byte i = rs[8i+7:8i]:
  - Stage 0: four products p_i = a_i*b_i, 17-bit signed. Operands are sign-extended if is_signed, else zero-extended.
  - Stage 1: sum = p0+p1+p2+p3, 19-bit signed, then sign-extended to XLEN. No overflow is possible.
  - Ranges: signed results lie in [-65024, 65536]; unsigned results lie in [0, 260100].
  - Lanes with tmask[j]=0 output 0; the product registers for those lanes are zeroed to save toggle.
- Latency: with result_ready held high, a transaction accepted at edge t has result_valid=1 in cycle t+LATENCY.
- Throughput: 1 transaction per cycle when unstalled.
- Ordering: strict FIFO; no reordering.
- Full condition: all LATENCY stages valid and result_ready=0 gives execute_ready=0. Accepted data is never dropped or duplicated.
- Simultaneous events: in the same cycle as a full pipeline with result_ready=1, execute_ready=1, so enqueue and dequeue occur together.
- Reset mid-operation: in-flight transactions are discarded, with no result emitted. Next accept is possible the cycle after reset deasserts.
- Tag and tmask travel with their data through every stage and are output unchanged.

Test Plan:
- Single transaction, signed: rs1=0x01020304, rs2=0x01010101, tmask=1111, ready=1 → result_valid exactly LATENCY cycles after accept, every lane = 10, tag echoed.
- Signed extremes: rs1=0x80808080, rs2=0x80808080 → 65536 (0x00010000). rs1=0x7F7F7F7F, rs2=0x80808080 → -65024 (0xFFFF0200). Unsigned with 0xFFFFFFFF·0xFFFFFFFF → 260100 (0x0003F804).
- Thread mask: tmask=0101, all lanes rs1=rs2=0x02020202 → lanes 0,2 = 16, lanes 1,3 = 0, result_tmask=0101.
- Back-to-back streaming: 100 random transactions with valid=1 and ready=1 → one accept per cycle, results in order, all equal to the reference model.
- Backpressure and bubble collapse: insert gaps, then hold result_ready=0 for 5 cycles → execute_ready drops only once all stages are valid; outputs stay stable; after release there is no loss or duplication. With the pipeline full and ready=1, enqueue and dequeue occur in the same cycle.
- Reset mid-flight: accept 2 transactions, assert reset for 1 cycle → no result_valid afterwards, execute_ready=1 in the first cycle after reset deasserts; next transaction is correct.

Source files
------------

// File: rtl/vx_alu_dot8.sv
// Packed int8/uint8 dot-product PE: per lane, sum of four byte products of rs1 and rs2.
// Latency: LATENCY cycles from accept to result_valid. S0 holds the products and S1 the
// lane sums; any further stages are plain registers.
// Backpressure: the stages form a stall chain that collapses bubbles. execute_ready drops
// only when every stage is valid and result_ready is low.
//
// Ports:
//   clk, reset        : clock; synchronous active-high reset (clears the stage valid bits only)
//   execute_*         : input transaction (valid/ready, tag, tmask, is_signed, rs1, rs2)
//   result_*          : output transaction (valid/ready, tag, tmask, per-lane XLEN-bit dot product)
module vx_alu_dot8 #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      execute_valid,
  output logic                      execute_ready,
  input  logic [TAG_WIDTH-1:0]      execute_tag,
  input  logic [NUM_LANES-1:0]      execute_tmask,
  input  logic                      execute_is_signed,
  input  logic [NUM_LANES*XLEN-1:0] execute_rs1,
  input  logic [NUM_LANES*XLEN-1:0] execute_rs2,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [TAG_WIDTH-1:0]      result_tag,
  output logic [NUM_LANES-1:0]      result_tmask,
  output logic [NUM_LANES*XLEN-1:0] result_data
);

  // A 9x9 signed byte product fits in 17 bits (65025 is the largest magnitude).
  // Four of these summed fit in 19 bits signed (260100 < 2^18).
  localparam int PW = 17;
  localparam int SW = 19;

  if (XLEN != 32 || LATENCY < 2) begin : g_param_check
    $error("vx_alu_dot8: XLEN must be 32 and LATENCY must be >= 2");
  end

  logic [LATENCY-1:0]                    v;
  logic [LATENCY-1:0]                    adv;
  logic [TAG_WIDTH-1:0]                  tag_q   [LATENCY];
  logic [NUM_LANES-1:0]                  tmask_q [LATENCY];
  logic [NUM_LANES-1:0][3:0][PW-1:0]     prod_d;
  logic [NUM_LANES-1:0][3:0][PW-1:0]     prod_q;
  logic [NUM_LANES*XLEN-1:0]             sum_d;
  // res_q[k] belongs to stage S(k+1); S0 carries products instead of sums.
  logic [NUM_LANES*XLEN-1:0]             res_q   [LATENCY-1];

  // Stall chain. adv[s] = !v[s] || adv[s+1], with the last stage tied to result_ready.
  // It is written in closed form: stage s may advance unless every stage from s to the
  // output is valid and the output is stalled. This avoids a combinational loop on the
  // adv vector.
  always_comb begin
    logic full_above;
    adv        = '0;
    full_above = 1'b0;
    for (int s = 0; s < LATENCY; s++) begin
      full_above = 1'b1;
      for (int k = s; k < LATENCY; k++) begin
        full_above = full_above & v[k];
      end
      adv[s] = result_ready || !full_above;
    end
  end

  assign execute_ready = adv[0];

  // Stage 0 multiply. Operands are widened to 9 bits (sign bit or zero) and then to the
  // product width, so one signed multiply covers both modes. Masked lanes load zeros so
  // their product registers do not toggle.
  always_comb begin
    logic [8:0]    a9;
    logic [8:0]    b9;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    prod_d = '0;
    a9     = '0;
    b9     = '0;
    a_ext  = '0;
    b_ext  = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      for (int i = 0; i < 4; i++) begin
        a9    = {execute_is_signed & execute_rs1[j*XLEN + 8*i + 7], execute_rs1[j*XLEN + 8*i +: 8]};
        b9    = {execute_is_signed & execute_rs2[j*XLEN + 8*i + 7], execute_rs2[j*XLEN + 8*i +: 8]};
        a_ext = {{(PW-9){a9[8]}}, a9};
        b_ext = {{(PW-9){b9[8]}}, b9};
        if (execute_tmask[j]) begin
          prod_d[j][i] = a_ext * b_ext;
        end
      end
    end
  end

  // Stage 1 add tree. The products are sign-extended, summed, and the sum is widened to
  // XLEN. Masked lanes already hold zero products, so their sum is zero.
  always_comb begin
    logic [SW-1:0] acc;
    sum_d = '0;
    acc   = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      acc = '0;
      for (int i = 0; i < 4; i++) begin
        acc = acc + {{(SW-PW){prod_q[j][i][PW-1]}}, prod_q[j][i]};
      end
      sum_d[j*XLEN +: XLEN] = {{(XLEN-SW){acc[SW-1]}}, acc};
    end
  end

  // Valid bits are the only reset state.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= execute_valid;
      end
      for (int s = 1; s < LATENCY; s++) begin
        if (adv[s]) begin
          v[s] <= v[s-1];
        end
      end
    end
  end

  // Payload registers. Each stage loads only when it advances and the incoming slot
  // holds a real transaction. A bubble leaves stale data behind, which is harmless
  // because the valid bit is cleared.
  always_ff @(posedge clk) begin
    if (adv[0] && execute_valid) begin
      prod_q     <= prod_d;
      tag_q[0]   <= execute_tag;
      tmask_q[0] <= execute_tmask;
    end
    if (adv[1] && v[0]) begin
      res_q[0]   <= sum_d;
      tag_q[1]   <= tag_q[0];
      tmask_q[1] <= tmask_q[0];
    end
    for (int s = 2; s < LATENCY; s++) begin
      if (adv[s] && v[s-1]) begin
        res_q[s-1]   <= res_q[s-2];
        tag_q[s]     <= tag_q[s-1];
        tmask_q[s]   <= tmask_q[s-1];
      end
    end
  end

  assign result_valid = v[LATENCY-1];
  assign result_tag   = tag_q[LATENCY-1];
  assign result_tmask = tmask_q[LATENCY-1];
  assign result_data  = res_q[LATENCY-2];

endmodule

// File: tb/tb_vx_alu_dot8.sv
module tb_vx_alu_dot8;
  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int LAT = 2;
  localparam int TW  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              execute_valid;
  logic              execute_ready;
  logic [TW-1:0]     execute_tag;
  logic [NL-1:0]     execute_tmask;
  logic              execute_is_signed;
  logic [NL*XL-1:0]  execute_rs1;
  logic [NL*XL-1:0]  execute_rs2;
  logic              result_valid;
  logic              result_ready;
  logic [TW-1:0]     result_tag;
  logic [NL-1:0]     result_tmask;
  logic [NL*XL-1:0]  result_data;

  always #5 clk = ~clk;

  vx_alu_dot8 #(.NUM_LANES(NL), .XLEN(XL), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .execute_valid(execute_valid), .execute_ready(execute_ready),
    .execute_tag(execute_tag), .execute_tmask(execute_tmask),
    .execute_is_signed(execute_is_signed),
    .execute_rs1(execute_rs1), .execute_rs2(execute_rs2),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_tag(result_tag), .result_tmask(result_tmask), .result_data(result_data)
  );

  typedef struct packed {
    logic [TW-1:0]    tag;
    logic [NL-1:0]    tm;
    logic [NL*XL-1:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_acc = 0, n_del = 0, occ_now = 0;
  logic acc_now, del_now, rv_now, rr_now, ready_now;
  txn_t out_now;

  // Reference: each lane is the plain integer sum of four byte products.
  function automatic logic [NL*XL-1:0] dot_model(input logic [NL*XL-1:0] a, input logic [NL*XL-1:0] b,
                                                 input logic [NL-1:0] tm, input logic sg);
    logic [NL*XL-1:0] r;
    r = '0;
    for (int j = 0; j < NL; j++) begin
      int acc;
      acc = 0;
      for (int i = 0; i < 4; i++) begin
        logic [7:0] x, y;
        int xi, yi;
        x  = a[j*XL + 8*i +: 8];
        y  = b[j*XL + 8*i +: 8];
        xi = sg ? int'($signed(x)) : int'(x);
        yi = sg ? int'($signed(y)) : int'(y);
        acc += xi * yi;
      end
      if (tm[j]) r[j*XL +: XL] = acc;
    end
    return r;
  endfunction

  // One clock of bookkeeping. It samples at the falling edge what will transfer at the
  // next rising edge, then returns just after that edge so the caller can drive again.
  task automatic step();
    @(negedge clk);
    occ_now   = n_acc - n_del;
    ready_now = execute_ready;
    rv_now    = result_valid;
    rr_now    = result_ready;
    acc_now   = execute_valid && execute_ready;
    del_now   = result_valid && result_ready;
    out_now   = {result_tag, result_tmask, result_data};
    if (acc_now === 1'b1) begin
      exp_q.push_back({execute_tag, execute_tmask,
                       dot_model(execute_rs1, execute_rs2, execute_tmask, execute_is_signed)});
      n_acc++;
    end
    if (del_now === 1'b1) begin
      obs_q.push_back(out_now);
      n_del++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [TW-1:0] tg, input logic [NL-1:0] tm, input logic sg,
                            input logic [31:0] a, input logic [31:0] b);
    execute_tag       = tg;
    execute_tmask     = tm;
    execute_is_signed = sg;
    execute_rs1       = {NL{a}};
    execute_rs2       = {NL{b}};
  endtask

  task automatic rand_fields();
    execute_tag       = {$urandom, $urandom};
    execute_tmask     = NL'($urandom);
    execute_is_signed = 1'($urandom);
    for (int j = 0; j < NL; j++) begin
      execute_rs1[j*XL +: XL] = $urandom;
      execute_rs2[j*XL +: XL] = $urandom;
    end
  endtask

  // Offers the current fields until they are accepted. waits = stall cycles, or -1 on timeout.
  task automatic send(output int waits);
    int n;
    execute_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (acc_now !== 1'b1 && n < 64);
    waits = (acc_now === 1'b1) ? n - 1 : -1;
  endtask

  task automatic drain(output bit ok);
    execute_valid = 1'b0;
    result_ready  = 1'b1;
    for (int n = 0; n < 50 && n_acc != n_del; n++) step();
    ok = (n_acc == n_del);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    execute_valid = 1'b0;
    result_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    n_acc = 0;
    n_del = 0;
    clear_sb();
    step();
    checks++;
    if (rv_now !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", rv_now);
    end
    checks++;
    if (ready_now !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", ready_now);
    end
  endtask

  task automatic test_single_signed();
    int w, n;
    bit ok;
    result_ready = 1'b1;
    set_fields(64'hDEAD_BEEF_0123_4567, 4'b1111, 1'b1, 32'h01020304, 32'h01010101);
    send(w);
    execute_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (rv_now !== 1'b1 && n < 20);
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL single_latency got %0d want %0d", n, LAT);
    end
    checks++;
    if (out_now.data !== {NL{32'd10}}) begin
      errors++;
      $display("FAIL single_data got %h want %h", out_now.data, {NL{32'd10}});
    end
    checks++;
    if (out_now.tag !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL single_tag got %h want deadbeef01234567", out_now.tag);
    end
    drain(ok);
    clear_sb();
  endtask

  task automatic test_extremes();
    int w;
    bit ok;
    result_ready = 1'b1;
    set_fields(64'h1, 4'hF, 1'b1, 32'h80808080, 32'h80808080); send(w);
    set_fields(64'h2, 4'hF, 1'b1, 32'h7F7F7F7F, 32'h80808080); send(w);
    set_fields(64'h3, 4'hF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF); send(w);
    drain(ok);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL extremes_count got %0d want 3", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].data !== {NL{32'h00010000}}) begin
        errors++;
        $display("FAIL ext_sminsq got %h want %h", obs_q[0].data, {NL{32'h00010000}});
      end
      checks++;
      if (obs_q[1].data !== {NL{32'hFFFF0200}}) begin
        errors++;
        $display("FAIL ext_smaxmin got %h want %h", obs_q[1].data, {NL{32'hFFFF0200}});
      end
      checks++;
      if (obs_q[2].data !== {NL{32'h0003F804}}) begin
        errors++;
        $display("FAIL ext_umax got %h want %h", obs_q[2].data, {NL{32'h0003F804}});
      end
    end
    clear_sb();
  endtask

  task automatic test_tmask();
    int w;
    bit ok;
    result_ready = 1'b1;
    set_fields(64'h55, 4'b0101, 1'b1, 32'h02020202, 32'h02020202);
    send(w);
    drain(ok);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL tmask_count got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].data !== {32'd0, 32'd16, 32'd0, 32'd16}) begin
        errors++;
        $display("FAIL tmask_data got %h want 00000000000000100000000000000010", obs_q[0].data);
      end
      checks++;
      if (obs_q[0].tm !== 4'b0101) begin
        errors++;
        $display("FAIL tmask_out got %b want 0101", obs_q[0].tm);
      end
    end
    clear_sb();
  endtask

  task automatic test_back_to_back();
    int w, stalls;
    bit ok;
    stalls = 0;
    result_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rand_fields();
      send(w);
      if (w != 0) stalls++;
    end
    drain(ok);
    checks++;
    if (stalls != 0 || !ok) begin
      errors++;
      $display("FAIL b2b_stalls got %0d drained=%0d want 0 stalls drained=1", stalls, ok);
    end
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 100) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d (model %0d)", obs_q.size(), 100, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL b2b[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    txn_t prev;
    logic prev_stall;
    bit   ok;
    prev = '0;
    // Gappy traffic with the output open.
    result_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_fields();
      execute_valid = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (ready_now !== ((occ_now < LAT) || rr_now)) begin
        errors++;
        $display("FAIL bp_ready_gap c=%0d got %b occ=%0d", c, ready_now, occ_now);
      end
    end
    // Output closed for 5 cycles while the input keeps offering.
    rand_fields();
    execute_valid = 1'b1;
    result_ready = 1'b0;
    prev_stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (ready_now !== ((occ_now < LAT) || rr_now)) begin
        errors++;
        $display("FAIL bp_ready_stall c=%0d got %b occ=%0d", c, ready_now, occ_now);
      end
      if (prev_stall && rv_now === 1'b1) begin
        checks++;
        if (out_now !== prev) begin
          errors++;
          $display("FAIL bp_hold c=%0d got %h want %h", c, out_now, prev);
        end
      end
      prev = out_now;
      prev_stall = (rv_now === 1'b1) && !rr_now;
      if (acc_now === 1'b1) rand_fields();
    end
    checks++;
    if (occ_now != LAT || ready_now !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got occ=%0d ready=%b want occ=%0d ready=0", occ_now, ready_now, LAT);
    end
    // Release with the pipe full: enqueue and dequeue on the same edge.
    result_ready = 1'b1;
    step();
    checks++;
    if (acc_now !== 1'b1 || del_now !== 1'b1) begin
      errors++;
      $display("FAIL bp_simul got acc=%b del=%b want 1 1", acc_now, del_now);
    end
    if (acc_now === 1'b1) rand_fields();
    // Random stalls on both sides.
    for (int c = 0; c < 30; c++) begin
      result_ready = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (ready_now !== ((occ_now < LAT) || rr_now)) begin
        errors++;
        $display("FAIL bp_ready_rand c=%0d got %b occ=%0d rr=%b", c, ready_now, occ_now, rr_now);
      end
      if (acc_now === 1'b1 || execute_valid == 1'b0) begin
        rand_fields();
        execute_valid = 1'($urandom_range(0, 1));
      end
    end
    drain(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d drained=%0d", obs_q.size(), exp_q.size(), ok);
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL bp[%0d] got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    clear_sb();
  endtask

  task automatic test_reset_midflight();
    int w, seen;
    bit ok;
    result_ready = 1'b0;
    rand_fields(); send(w);
    rand_fields(); send(w);
    execute_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_acc = 0;
    n_del = 0;
    clear_sb();
    step();
    checks++;
    if (ready_now !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready got %b want 1", ready_now);
    end
    seen = (rv_now === 1'b1) ? 1 : 0;
    result_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rv_now === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_valid got %0d results want 0", seen);
    end
    set_fields(64'hABCD, 4'b1011, 1'b1, 32'hF0E1D2C3, 32'h11223344);
    send(w);
    drain(ok);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_count got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL rst_mid_next got %h want %h", obs_q[0], exp_q[0]);
      end
    end
    clear_sb();
  endtask

  initial begin
    reset = 1'b1;
    execute_valid = 1'b0;
    result_ready = 1'b1;
    execute_tag = '0;
    execute_tmask = '0;
    execute_is_signed = 1'b0;
    execute_rs1 = '0;
    execute_rs2 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_signed();
    test_extremes();
    test_tmask();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
